// File: rtl/dsp48_pkg.sv
// -----------------------------------------------------------------------------
// dsp48_pkg
//   Shared definitions for the DSP48A1 slice model.
//
//   Contents:
//     N_P, N_M       default widths of the P datapath and of the multiplier
//                    result M
//     OPM_*          bit positions of the fields inside OPMODE
//     x_sel_e        X operand select codes (OPMODE[1:0])
//     z_sel_e        Z operand select codes (OPMODE[3:2])
// -----------------------------------------------------------------------------
package dsp48_pkg;

  // Default datapath widths.
  localparam int N_P = 48;
  localparam int N_M = 36;

  // OPMODE field positions. Bits 4 and 6 belong to the pre-adder / multiplier
  // side of the slice and are not consumed by the post-adder.
  localparam int OPM_X_LSB = 0;
  localparam int OPM_X_MSB = 1;
  localparam int OPM_Z_LSB = 2;
  localparam int OPM_Z_MSB = 3;
  localparam int OPM_CIN   = 5;
  localparam int OPM_SUB   = 7;

  // X multiplexer codes.
  typedef enum logic [1:0] {
    X_ZERO = 2'b00,
    X_M    = 2'b01,
    X_P    = 2'b10,
    X_DAB  = 2'b11
  } x_sel_e;

  // Z multiplexer codes.
  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_PCIN = 2'b01,
    Z_P    = 2'b10,
    Z_C    = 2'b11
  } z_sel_e;

endpackage : dsp48_pkg

// File: rtl/dsp_xz_sel.sv
// -----------------------------------------------------------------------------
// dsp_xz_sel
//   Combinational X/Z operand selection for the post-adder.
//
//   Ports:
//     x_sel  in   x_sel_e  X source: zero / M / P feedback / D:A:B
//     z_sel  in   z_sel_e  Z source: zero / PCIN / P feedback / C
//     m      in   N_M      multiplier result, unsigned (zero-extended)
//     c      in   N_P      C operand
//     dab    in   N_P      {D[11:0], A[17:0], B[17:0]}
//     pcin   in   N_P      cascade input from the previous slice
//     p      in   N_P      current P register (accumulate feedback)
//     x      out  N_P      selected X operand
//     z      out  N_P      selected Z operand
// -----------------------------------------------------------------------------
module dsp_xz_sel #(
  parameter int N_P = dsp48_pkg::N_P,
  parameter int N_M = dsp48_pkg::N_M
) (
  input  dsp48_pkg::x_sel_e x_sel,
  input  dsp48_pkg::z_sel_e z_sel,
  input  logic [N_M-1:0]    m,
  input  logic [N_P-1:0]    c,
  input  logic [N_P-1:0]    dab,
  input  logic [N_P-1:0]    pcin,
  input  logic [N_P-1:0]    p,
  output logic [N_P-1:0]    x,
  output logic [N_P-1:0]    z
);

  import dsp48_pkg::*;

  // M is an unsigned product, so the upper bits are filled with zeros.
  logic [N_P-1:0] m_ext;
  assign m_ext = {{(N_P-N_M){1'b0}}, m};

  always_comb begin
    x = '0;
    case (x_sel)
      X_ZERO:  x = '0;
      X_M:     x = m_ext;
      X_P:     x = p;
      X_DAB:   x = dab;
      default: x = '0;
    endcase
  end

  always_comb begin
    z = '0;
    case (z_sel)
      Z_ZERO:  z = '0;
      Z_PCIN:  z = pcin;
      Z_P:     z = p;
      Z_C:     z = c;
      default: z = '0;
    endcase
  end

endmodule : dsp_xz_sel

// File: rtl/dsp_post_adder.sv
// -----------------------------------------------------------------------------
// dsp_post_adder
//   Post-adder / accumulator stage of the DSP48A1 slice model. Selects X and Z
//   operands from OPMODE, adds or subtracts them together with a registered
//   carry-in, and holds the result in the P register.
//
//   Optional build macro:
//     DSP_OPMODE_REG_EN  when defined, OPMODE is registered (enable CEOPMODE)
//                        and every OPMODE-controlled path uses the registered
//                        copy; when undefined OPMODE is used directly and
//                        CEOPMODE is ignored.
//
//   Parameters:
//     N_P         width of P / C / PCIN / D:A:B paths
//     N_M         width of multiplier result M
//     CARRYINSEL  "OPMODE5": carry-in from OPMODE[5]; "CARRYIN": from the port
//
//   Ports:
//     CLK        in   1    slice clock, rising edge
//     rst        in   1    synchronous active-high reset of every register
//     CEP        in   1    P / carry-out register enable
//     CECARRYIN  in   1    carry-in register enable
//     CEOPMODE   in   1    OPMODE register enable (macro builds only)
//     OPMODE     in   8    [1:0] X sel, [3:2] Z sel, [5] carry-in, [7] subtract
//     M          in   N_M  multiplier register output
//     C          in   N_P  C operand
//     DAB        in   N_P  {D, A, B} concatenation
//     PCIN       in   N_P  cascade input
//     CARRYIN    in   1    fabric carry-in
//     P          out  N_P  registered result
//     PCOUT      out  N_P  cascade output, equal to P
//     CARRYOUT   out  1    registered carry / borrow
//     CARRYOUTF  out  1    fabric copy of CARRYOUT
// -----------------------------------------------------------------------------
module dsp_post_adder #(
  parameter int N_P        = dsp48_pkg::N_P,
  parameter int N_M        = dsp48_pkg::N_M,
  parameter     CARRYINSEL = "OPMODE5"
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic           CEP,
  input  logic           CECARRYIN,
  input  logic           CEOPMODE,
  input  logic [7:0]     OPMODE,
  input  logic [N_M-1:0] M,
  input  logic [N_P-1:0] C,
  input  logic [N_P-1:0] DAB,
  input  logic [N_P-1:0] PCIN,
  input  logic           CARRYIN,
  output logic [N_P-1:0] P,
  output logic [N_P-1:0] PCOUT,
  output logic           CARRYOUT,
  output logic           CARRYOUTF
);

  import dsp48_pkg::*;

  localparam bit CYI_FROM_PORT = (CARRYINSEL == "CARRYIN");

  // ---------------------------------------------------------------------------
  // Effective OPMODE
  // ---------------------------------------------------------------------------
  logic [7:0] opmode_eff;

`ifdef DSP_OPMODE_REG_EN
  logic [7:0] opmode_reg;

  always_ff @(posedge CLK) begin
    if (rst) begin
      opmode_reg <= '0;
    end else if (CEOPMODE) begin
      opmode_reg <= OPMODE;
    end
  end

  assign opmode_eff = opmode_reg;

  // Bits 4 and 6 drive the multiplier side of the slice, not this stage.
  logic unused_opmode_bits;
  assign unused_opmode_bits = ^{opmode_eff[6], opmode_eff[4]};
`else
  assign opmode_eff = OPMODE;

  // Without the OPMODE register the enable has nothing to gate.
  logic unused_opmode_bits;
  assign unused_opmode_bits = ^{CEOPMODE, opmode_eff[6], opmode_eff[4]};
`endif

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [N_P-1:0] p_reg;
  logic           cyo_reg;
  logic           cyi_reg;

  logic [N_P-1:0] p_next;
  logic           cyo_next;
  logic           cyi_next;

  // ---------------------------------------------------------------------------
  // Operand selection
  // ---------------------------------------------------------------------------
  logic [N_P-1:0] x_op;
  logic [N_P-1:0] z_op;
  x_sel_e         x_sel;
  z_sel_e         z_sel;

  assign x_sel = x_sel_e'(opmode_eff[OPM_X_MSB:OPM_X_LSB]);
  assign z_sel = z_sel_e'(opmode_eff[OPM_Z_MSB:OPM_Z_LSB]);

  // P feedback is the register output, so accumulation always sees the value
  // from before the current edge.
  dsp_xz_sel #(
    .N_P (N_P),
    .N_M (N_M)
  ) u_xz_sel (
    .x_sel (x_sel),
    .z_sel (z_sel),
    .m     (M),
    .c     (C),
    .dab   (DAB),
    .pcin  (PCIN),
    .p     (p_reg),
    .x     (x_op),
    .z     (z_op)
  );

  // ---------------------------------------------------------------------------
  // Post-adder
  // ---------------------------------------------------------------------------
  // Both operations run one bit wider than P. In subtract mode the carry-in
  // is folded into the subtrahend, so bit N_P of the wrapped difference is the
  // borrow flag.
  logic [N_P:0] x_ext;
  logic [N_P:0] z_ext;
  logic [N_P:0] addend;
  logic [N_P:0] sum_ext;
  logic         sub_mode;

  assign sub_mode = opmode_eff[OPM_SUB];
  assign x_ext    = {1'b0, x_op};
  assign z_ext    = {1'b0, z_op};
  assign addend   = x_ext + {{N_P{1'b0}}, cyi_reg};
  assign sum_ext  = sub_mode ? (z_ext - addend) : (z_ext + addend);

  assign p_next   = sum_ext[N_P-1:0];
  assign cyo_next = sum_ext[N_P];

  // Carry source is fixed at elaboration; CARRYINSEL never changes at run time.
  assign cyi_next = CYI_FROM_PORT ? CARRYIN : opmode_eff[OPM_CIN];

  // ---------------------------------------------------------------------------
  // P, carry-out and carry-in registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (rst) begin
      p_reg   <= '0;
      cyo_reg <= 1'b0;
    end else if (CEP) begin
      p_reg   <= p_next;
      cyo_reg <= cyo_next;
    end
  end

  // Loaded on the same edge that P consumes the old value, giving the
  // two-edge carry-source-to-P latency.
  always_ff @(posedge CLK) begin
    if (rst) begin
      cyi_reg <= 1'b0;
    end else if (CECARRYIN) begin
      cyi_reg <= cyi_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign P         = p_reg;
  assign PCOUT     = p_reg;
  assign CARRYOUT  = cyo_reg;
  assign CARRYOUTF = cyo_reg;

endmodule : dsp_post_adder

// File: tb/tb_dsp_post_adder.sv
// -----------------------------------------------------------------------------
// tb_dsp_post_adder
//   Self-checking bench for dsp_post_adder. Two instances share the stimulus:
//   one takes its carry-in from the CARRYIN port, the other from OPMODE[5].
//   A reference model computes P and the carry with 64-bit integer arithmetic
//   after every rising edge; outputs are compared 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_dsp_post_adder;

  localparam int NP = 48;
  localparam int NM = 36;
  localparam logic [63:0] MASK49 = (64'd1 << 49) - 64'd1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cep;
  logic          cecarryin;
  logic          ceopmode;
  logic [7:0]    opmode;
  logic [NM-1:0] m_in;
  logic [NP-1:0] c_in;
  logic [NP-1:0] dab_in;
  logic [NP-1:0] pcin_in;
  logic          carryin;

  logic [NP-1:0] p_a, pcout_a, p_b, pcout_b;
  logic          co_a, cof_a, co_b, cof_b;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = CARRYIN instance, index 1 = OPMODE5 instance.
  logic [NP-1:0] mdl_p   [2];
  logic          mdl_cyo [2];
  logic          mdl_cyi [2];
  logic [7:0]    mdl_opm;

  always #5 clk = ~clk;

  dsp_post_adder #(.N_P(NP), .N_M(NM), .CARRYINSEL("CARRYIN")) dut_a (
    .CLK(clk), .rst(rst), .CEP(cep), .CECARRYIN(cecarryin), .CEOPMODE(ceopmode),
    .OPMODE(opmode), .M(m_in), .C(c_in), .DAB(dab_in), .PCIN(pcin_in),
    .CARRYIN(carryin), .P(p_a), .PCOUT(pcout_a), .CARRYOUT(co_a), .CARRYOUTF(cof_a)
  );

  dsp_post_adder #(.N_P(NP), .N_M(NM), .CARRYINSEL("OPMODE5")) dut_b (
    .CLK(clk), .rst(rst), .CEP(cep), .CECARRYIN(cecarryin), .CEOPMODE(ceopmode),
    .OPMODE(opmode), .M(m_in), .C(c_in), .DAB(dab_in), .PCIN(pcin_in),
    .CARRYIN(carryin), .P(p_b), .PCOUT(pcout_b), .CARRYOUT(co_b), .CARRYOUTF(cof_b)
  );

  // Behavioural model of one rising edge, using the inputs currently applied.
  task automatic model_edge();
    logic [7:0]  opm;
    logic [63:0] x, z, r;
`ifdef DSP_OPMODE_REG_EN
    opm = mdl_opm;
`else
    opm = opmode;
`endif
    for (int k = 0; k < 2; k++) begin
      case (opm[1:0])
        2'd0:    x = 64'd0;
        2'd1:    x = {28'd0, m_in};
        2'd2:    x = {16'd0, mdl_p[k]};
        default: x = {16'd0, dab_in};
      endcase
      case (opm[3:2])
        2'd0:    z = 64'd0;
        2'd1:    z = {16'd0, pcin_in};
        2'd2:    z = {16'd0, mdl_p[k]};
        default: z = {16'd0, c_in};
      endcase
      if (opm[7]) r = (z - x - {63'd0, mdl_cyi[k]}) & MASK49;
      else        r = (z + x + {63'd0, mdl_cyi[k]}) & MASK49;
      if (rst) begin
        mdl_p[k]   = '0;
        mdl_cyo[k] = 1'b0;
        mdl_cyi[k] = 1'b0;
      end else begin
        if (cep) begin
          mdl_p[k]   = r[NP-1:0];
          mdl_cyo[k] = r[NP];
        end
        if (cecarryin) mdl_cyi[k] = (k == 0) ? carryin : opm[5];
      end
    end
    if (rst)           mdl_opm = 8'd0;
    else if (ceopmode) mdl_opm = opmode;
  endtask

  task automatic check(input string tag, input logic [NP-1:0] got, input logic [NP-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock edge followed by the full set of output comparisons.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check($sformatf("%s/P_cin", tag),      p_a,            mdl_p[0]);
    check($sformatf("%s/PCOUT_cin", tag),  pcout_a,        mdl_p[0]);
    check($sformatf("%s/CO_cin", tag),     {47'd0, co_a},  {47'd0, mdl_cyo[0]});
    check($sformatf("%s/COF_cin", tag),    {47'd0, cof_a}, {47'd0, mdl_cyo[0]});
    check($sformatf("%s/P_op5", tag),      p_b,            mdl_p[1]);
    check($sformatf("%s/PCOUT_op5", tag),  pcout_b,        mdl_p[1]);
    check($sformatf("%s/CO_op5", tag),     {47'd0, co_b},  {47'd0, mdl_cyo[1]});
    check($sformatf("%s/COF_op5", tag),    {47'd0, cof_b}, {47'd0, mdl_cyo[1]});
    $display("%s: opmode=%b rst=%b cep=%b P=%h CO=%b P5=%h CO5=%b",
             tag, opmode, rst, cep, p_a, co_a, p_b, co_b);
  endtask

  task automatic set_idle();
    rst = 1'b0; cep = 1'b1; cecarryin = 1'b1; ceopmode = 1'b1;
    opmode = 8'd0; m_in = '0; c_in = '0; dab_in = '0; pcin_in = '0; carryin = 1'b0;
  endtask

  initial begin
    logic [63:0] rnd;
    for (int k = 0; k < 2; k++) begin
      mdl_p[k] = '0; mdl_cyo[k] = 1'b0; mdl_cyi[k] = 1'b0;
    end
    mdl_opm = 8'd0;
    set_idle();

    // Reset held for two edges with CEP=1.
    rst = 1'b1;
    tick("reset0");
    tick("reset1");
    rst = 1'b0;

    // Multiply-add: X=M, Z=C.
    opmode = 8'b0000_1101; m_in = 36'd100; c_in = 48'd5;
    tick("madd0");
    tick("madd1");

    // Accumulate X=M, Z=P from reset, then freeze with CEP=0.
    rst = 1'b1; opmode = 8'b0000_1001; m_in = 36'd3;
    tick("acc_rst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick($sformatf("acc%0d", i));
    cep = 1'b0;
    tick("acc_hold0");
    tick("acc_hold1");
    cep = 1'b1;

    // Subtract with borrow: Z=C=2, X=DAB=5.
    opmode = 8'b1000_1111; c_in = 48'd2; dab_in = 48'd5;
    tick("sub0");
    tick("sub1");

    // Carry-in latency: one-edge CARRYIN pulse with X=Z=0.
    opmode = 8'b0000_0000; carryin = 1'b1; cecarryin = 1'b1;
    tick("cin_pulse");
    carryin = 1'b0; cecarryin = 1'b0;
    tick("cin_edge2");
    tick("cin_edge3");
    cecarryin = 1'b1;
    tick("cin_clear");

    // Carry from OPMODE[5], with CECARRYIN then dropped.
    opmode = 8'b0010_0000;
    tick("op5_load");
    tick("op5_use");
    opmode = 8'b0000_0000;
    tick("op5_clear0");
    tick("op5_clear1");

    // Overflow wrap: C all ones plus DAB=1.
    opmode = 8'b0000_1111; c_in = 48'hFFFF_FFFF_FFFF; dab_in = 48'd1;
    tick("wrap0");
    tick("wrap1");

    // Reset mid-accumulation, then resume from zero.
    opmode = 8'b0000_1001; m_in = 36'd7;
    tick("racc0");
    rst = 1'b1;
    tick("racc_rst");
    rst = 1'b0;
    tick("racc1");
    tick("racc2");

    // OPMODE change timing with CEOPMODE held low.
    ceopmode = 1'b0; opmode = 8'b0000_1111; c_in = 48'd40; dab_in = 48'd2;
    tick("opm_gate0");
    ceopmode = 1'b1;
    tick("opm_gate1");
    tick("opm_gate2");

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 31) == 0);
      cep       = ($urandom_range(0, 7) != 0);
      cecarryin = ($urandom_range(0, 3) != 0);
      ceopmode  = ($urandom_range(0, 3) != 0);
      carryin   = $urandom_range(0, 1) == 1;
      opmode    = 8'($urandom_range(0, 255));
      rnd = {$urandom(), $urandom()}; m_in    = rnd[NM-1:0];
      rnd = {$urandom(), $urandom()}; c_in    = rnd[NP-1:0];
      rnd = {$urandom(), $urandom()}; dab_in  = rnd[NP-1:0];
      rnd = {$urandom(), $urandom()}; pcin_in = rnd[NP-1:0];
      if ($urandom_range(0, 7) == 0) c_in = '1;
      if ($urandom_range(0, 7) == 0) dab_in = 48'd1;
      tick($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dsp_post_adder

// File: doc/dsp_post_adder.md
# dsp_post_adder

Post-adder/accumulator stage of the DSP48A1 slice model. It consumes the multiplier register output M, the C port, the D:A:B concatenation and the cascade input PCIN. It selects X and Z operands per OPMODE and adds or subtracts them with a registered carry-in. The result is held in the P register, which drives P, PCOUT and the carry outputs back into the fabric and the next slice.

## Interface
Parameters:
- N_P, 48, width of P/C/PCIN/D:A:B paths
- N_M, 36, width of multiplier result M
- CARRYINSEL, "OPMODE5", carry-in source: "OPMODE5" uses OPMODE[5]; "CARRYIN" uses the CARRYIN port

Ports:
- CLK  input  1  slice clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high; clears every register in the block
- CEP  input  1  P/CYO register clock enable
- CECARRYIN  input  1  carry-in register (CYI) enable
- CEOPMODE  input  1  OPMODE register enable (used only when DSP_OPMODE_REG_EN is defined)
- OPMODE  input  8  [1:0] X select, [3:2] Z select, [5] carry-in, [7] post-subtract; [4] and [6] are ignored here
- M  input  N_M  multiplier register output, unsigned, zero-extended to N_P
- C  input  N_P  C operand
- DAB  input  N_P  {D[11:0], A[17:0], B[17:0]}
- PCIN  input  N_P  cascade input from the previous slice
- CARRYIN  input  1  fabric carry-in
- P  output  N_P  registered result
- PCOUT  output  N_P  equals P
- CARRYOUT  output  1  registered carry/borrow
- CARRYOUTF  output  1  equals CARRYOUT

## Operation
- X mux (OPMODE[1:0]): 00 → 0; 01 → {zeros, M}; 10 → P (feedback); 11 → DAB.
- Z mux (OPMODE[3:2]): 00 → 0; 01 → PCIN; 10 → P (feedback); 11 → C.
- CYI register: when CECARRYIN=1, it loads the selected carry source (OPMODE[5] or CARRYIN, according to CARRYINSEL). Otherwise it holds.
- Add (OPMODE[7]=0): {co, s} = {0,Z} + {0,X} + CYI, computed at N_P+1 bits.
- Subtract (OPMODE[7]=1): {co, s} = {0,Z} − ({0,X} + CYI), modulo 2^(N_P+1). co is bit N_P, which is 1 on borrow.
- When CEP=1, P ← s and CYO ← co. When CEP=0, both hold.
- Accumulate (X or Z = P) uses the P value from before the current edge.
- Wrap-around: the sum is truncated to N_P bits. There is no saturation; overflow is visible only through CARRYOUT.
- Reset: rst=1 at an edge sets P=0, CYO=0, CYI=0, and OPMODE reg=0 (when the macro is present). Reset wins over all enables.
- Reset mid-accumulation: the next edge with rst=0 and CEP=1 accumulates starting from 0.

## Timing
- M, C, DAB, PCIN to P: 1 edge, provided CEP=1 at that edge.
- Carry source to P: 2 edges (the CYI edge, then the P edge).
- OPMODE to effect:
  - 0 edges (combinational) without the macro.
  - 1 extra edge with the macro, gated by CEOPMODE.
- Outputs after reset: P=PCOUT=0, CARRYOUT=CARRYOUTF=0.
- Simultaneous CECARRYIN and CEP at the same edge: P uses the old CYI; CYI loads the new value.

## Configuration
- DSP_OPMODE_REG_EN:
  - Defined: OPMODE passes through a register (enable CEOPMODE, sync reset to 0), and the muxes and subtract use the registered copy.
  - Undefined: OPMODE is used directly, and CEOPMODE is unused.

## Structure
- Shared package dsp48_pkg holds:
  - N_P, N_M width constants
  - OPMODE bit-position constants
  - X_SEL/Z_SEL enum codes (ZERO, M/PCIN, P, DAB/C)
- One sub-module, dsp_xz_sel: the combinational X/Z operand selection. The adder and the registers stay in the top level.

## Test plan
- Reset: drive rst=1 for 2 cycles with CEP=1 → P=0 and CARRYOUT=0 on every cycle.
- Multiply-add: OPMODE=8'b0000_1101 (X=M, Z=C), M=100, C=5, CYI=0, CEP=1 → P=105 one edge later.
- Accumulate: OPMODE X=M, Z=P, M=3, held for 4 edges from reset → P = 3, 6, 9, 12; then CEP=0 → P stays 12.
- Subtract with borrow: OPMODE[7]=1, Z=C=2, X=DAB=5, CYI=0 → P = 2^48−3, CARRYOUT=1.
- Carry-in latency: CARRYINSEL="CARRYIN", CARRYIN=1 pulsed with CECARRYIN=1, X=Z=0 → P=1 exactly 2 edges after the pulse.
- Overflow wrap: Z=C=48'hFFFF_FFFF_FFFF, X=DAB=1 → P=0, CARRYOUT=1. With DSP_OPMODE_REG_EN, an OPMODE change takes effect one edge later than without it.
